// File: rtl/mips_fetch_unit.sv
// Multi-cycle MIPS instruction fetch/sequencing unit: REQ/HOLD handshake with imem, next-PC select.
// Optional fetch timeout fault enabled by defining FETCH_TIMEOUT_EN.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [5:0]  op_out,
  output logic [5:0]  func_out,
  input  logic        instr_ready_in,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        zero_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] retired_count_out,
  output logic        fault_out
);

  typedef enum logic [1:0] {S_REQ, S_HOLD, S_FAULT} state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic [31:0] w_pc_plus4;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc4 + $unsigned(off);
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc4, input logic [31:0] instr,
                                          input logic jump, input logic branch, input logic zero);
    if (jump)
      return {pc4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      return branch_target(pc4, instr[15:0]);
    else
      return pc4;
  endfunction

  assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] r_wait;
  logic        r_fault;
  assign fault_out = r_fault;
`else
  assign fault_out = 1'b0;
`endif

  // r_req is low for the first REQ cycle after reset, so an ack arriving then is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_REQ;
      r_req     <= 1'b0;
      r_valid   <= 1'b0;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_retired <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      r_wait    <= 32'd0;
      r_fault   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (r_req && imem_ack_in) begin
            r_instr <= imem_data_in;
            r_valid <= 1'b1;
            r_req   <= 1'b0;
            r_state <= S_HOLD;
`ifdef FETCH_TIMEOUT_EN
          end else if (r_req && (r_wait == TIMEOUT - 1)) begin
            r_req   <= 1'b0;
            r_fault <= 1'b1;
            r_state <= S_FAULT;
`endif
          end else begin
            r_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
            if (r_req) r_wait <= r_wait + 32'd1;
`endif
          end
        end
        S_HOLD: begin
          if (instr_ready_in) begin
            r_pc      <= next_pc(w_pc_plus4, r_instr, jump_in, branch_in, zero_in);
            r_retired <= r_retired + 32'd1;
            r_valid   <= 1'b0;
            r_req     <= 1'b1;
            r_state   <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            r_wait    <= 32'd0;
`endif
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_out      = r_req;
  assign imem_addr_out     = r_pc;
  assign instr_valid_out   = r_valid;
  assign instr_out         = r_instr;
  assign op_out            = r_instr[31:26];
  assign func_out          = r_instr[5:0];
  assign pc_out            = r_pc;
  assign pc_plus4_out      = w_pc_plus4;
  assign retired_count_out = r_retired;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: straight-line, branch, jump, stall, wrap, reset, timeout.
module tb_mips_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ack = 1'b0;
  logic [31:0] data = 32'd0;
  logic ready = 1'b0;
  logic branch = 1'b0;
  logic jump = 1'b0;
  logic zero = 1'b0;

  logic        a_req, a_valid, a_fault, b_req, b_valid, b_fault;
  logic [31:0] a_addr, a_instr, a_pc, a_pc4, a_cnt, b_addr, b_instr, b_pc, b_pc4, b_cnt;
  logic [5:0]  a_op, a_func, b_op, b_func;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_fetch_unit #(.RESET_PC(32'h0000_0100), .TIMEOUT(4)) u_dut (
    .clk(clk), .reset(reset), .imem_req_out(a_req), .imem_addr_out(a_addr),
    .imem_ack_in(ack), .imem_data_in(data), .instr_valid_out(a_valid), .instr_out(a_instr),
    .op_out(a_op), .func_out(a_func), .instr_ready_in(ready), .branch_in(branch),
    .jump_in(jump), .zero_in(zero), .pc_out(a_pc), .pc_plus4_out(a_pc4),
    .retired_count_out(a_cnt), .fault_out(a_fault)
  );

  // Second instance with a high reset PC, used to observe the jump region bits.
  mips_fetch_unit #(.RESET_PC(32'h4000_0010), .TIMEOUT(4)) u_dut_hi (
    .clk(clk), .reset(reset), .imem_req_out(b_req), .imem_addr_out(b_addr),
    .imem_ack_in(ack), .imem_data_in(data), .instr_valid_out(b_valid), .instr_out(b_instr),
    .op_out(b_op), .func_out(b_func), .instr_ready_in(ready), .branch_in(branch),
    .jump_in(jump), .zero_in(zero), .pc_out(b_pc), .pc_plus4_out(b_pc4),
    .retired_count_out(b_cnt), .fault_out(b_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr_exp, input logic [31:0] word, input int delay);
    int n;
    logic [31:0] w;
    n = 0;
    w = word;
    while (a_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_up", {31'd0, a_req}, 32'd1);
    chk("fetch_addr", a_addr, addr_exp);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("stall_addr", a_addr, addr_exp);
      chk("stall_req", {31'd0, a_req}, 32'd1);
      chk("stall_vld", {31'd0, a_valid}, 32'd0);
    end
    ack = 1'b1;
    data = w;
    step();
    ack = 1'b0;
    data = 32'hDEAD_BEEF;
    chk("vld_up", {31'd0, a_valid}, 32'd1);
    chk("req_low", {31'd0, a_req}, 32'd0);
    chk("instr", a_instr, w);
    chk("op", {26'd0, a_op}, {26'd0, w[31:26]});
    chk("func", {26'd0, a_func}, {26'd0, w[5:0]});
    chk("pc_out", a_pc, addr_exp);
    chk("pc_plus4", a_pc4, addr_exp + 32'd4);
  endtask

  task automatic retire(input logic j, input logic b, input logic z, input int hold,
                        input logic [31:0] next_exp, input logic [31:0] cnt_exp);
    logic [5:0] op0;
    op0 = a_op;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_vld", {31'd0, a_valid}, 32'd1);
      chk("hold_req", {31'd0, a_req}, 32'd0);
      chk("hold_op", {26'd0, a_op}, {26'd0, op0});
    end
    ready = 1'b1;
    jump = j;
    branch = b;
    zero = z;
    step();
    ready = 1'b0;
    jump = 1'b0;
    branch = 1'b0;
    zero = 1'b0;
    chk("ret_vld", {31'd0, a_valid}, 32'd0);
    chk("ret_req", {31'd0, a_req}, 32'd1);
    chk("next_addr", a_addr, next_exp);
    chk("retired", a_cnt, cnt_exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    chk("rst_req", {31'd0, a_req}, 32'd0);
    chk("rst_vld", {31'd0, a_valid}, 32'd0);
    chk("rst_instr", a_instr, 32'd0);
    chk("rst_cnt", a_cnt, 32'd0);
    chk("rst_fault", {31'd0, a_fault}, 32'd0);
    chk("rst_addr", a_addr, 32'h0000_0100);
    chk("rst_addr_hi", b_addr, 32'h4000_0010);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    do_reset();

    // Straight-line fetch
    fetch(32'h0000_0100, 32'h2002_0005, 0);
    retire(1'b0, 1'b0, 1'b0, 0, 32'h0000_0104, 32'd1);
    fetch(32'h0000_0104, 32'h0000_0020, 0);
    retire(1'b0, 1'b0, 1'b0, 0, 32'h0000_0108, 32'd2);
    fetch(32'h0000_0108, 32'h8C22_0004, 0);
    retire(1'b0, 1'b0, 1'b0, 0, 32'h0000_010C, 32'd3);

    // Jump beats branch; high instance keeps its top nibble
    do_reset();
    fetch(32'h0000_0100, 32'h0800_0040, 0);
    retire(1'b1, 1'b1, 1'b1, 0, 32'h0000_0100, 32'd1);
    chk("jump_hi", b_addr, 32'h4000_0100);

    // Branches
    fetch(32'h0000_0100, 32'h1000_003F, 0);
    retire(1'b0, 1'b1, 1'b1, 0, 32'h0000_0200, 32'd2);
    fetch(32'h0000_0200, 32'h1000_FFFE, 0);
    retire(1'b0, 1'b1, 1'b1, 0, 32'h0000_01FC, 32'd3);
    fetch(32'h0000_01FC, 32'h1000_FFFE, 0);
    retire(1'b0, 1'b1, 1'b0, 0, 32'h0000_0200, 32'd4);
    fetch(32'h0000_0200, 32'h1000_FFFE, 0);
    retire(1'b0, 1'b1, 1'b0, 0, 32'h0000_0204, 32'd5);

    // Stall on both sides, then wrap through the top of memory
    fetch(32'h0000_0204, 32'h1000_FF7D, 5);
    retire(1'b0, 1'b1, 1'b1, 4, 32'hFFFF_FFFC, 32'd6);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 0);
    retire(1'b0, 1'b0, 1'b0, 0, 32'h0000_0000, 32'd7);

    // Reset while a request is pending, ack still high after reset drops
    ack = 1'b1;
    data = 32'h1234_5678;
    reset = 1'b1;
    step();
    chk("mid_rst_req", {31'd0, a_req}, 32'd0);
    chk("mid_rst_addr", a_addr, 32'h0000_0100);
    chk("mid_rst_cnt", a_cnt, 32'd0);
    reset = 1'b0;
    step();
    ack = 1'b0;
    chk("late_ack_vld", {31'd0, a_valid}, 32'd0);
    chk("late_ack_instr", a_instr, 32'd0);
    chk("late_ack_req", {31'd0, a_req}, 32'd1);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_nofault", {31'd0, a_fault}, 32'd0);
      chk("to_req", {31'd0, a_req}, 32'd1);
    end
    step();
    chk("to_fault", {31'd0, a_fault}, 32'd1);
    chk("to_req_low", {31'd0, a_req}, 32'd0);
    chk("to_vld_low", {31'd0, a_valid}, 32'd0);
    ack = 1'b1;
    data = 32'hCAFE_0001;
    step();
    step();
    ack = 1'b0;
    chk("fault_sticky", {31'd0, a_fault}, 32'd1);
    chk("fault_no_vld", {31'd0, a_valid}, 32'd0);
    do_reset();
    step();
    for (int i = 0; i < 3; i++) step();
    ack = 1'b1;
    data = 32'hCAFE_0002;
    step();
    ack = 1'b0;
    chk("edge_ack_fault", {31'd0, a_fault}, 32'd0);
    chk("edge_ack_vld", {31'd0, a_valid}, 32'd1);
    chk("edge_ack_instr", a_instr, 32'hCAFE_0002);
`else
    for (int i = 0; i < 20; i++) step();
    chk("no_to_fault", {31'd0, a_fault}, 32'd0);
    chk("no_to_req", {31'd0, a_req}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
